fsm7_seq_checker: RTL and testbench
===================================

Name: fsm7_seq_checker

Overview:
- Receiving end of the 4-bit sequence bus driven by the 7-state cycling counter FSM.
- That FSM emits 8 once after reset, then cycles 7,6,5,4,3,2,1,7,...
- This block samples the bus, locks onto the sequence, and flags errors and restarts.
- It counts completed loops and errors for the board display and the test logic.

Parameters:
- LOCK_THRESH, 3: consecutive correct samples needed to assert locked.
- LOSS_THRESH, 2: consecutive mismatches in LOCK that drop lock.
- CNT_W, 8: width of loop_cnt and err_cnt.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- cq_in  input  4  sequence value from the counter FSM.
- cq_valid  input  1  sample enable; when low, state holds and no pulse is generated.
- locked  output  1  high while in LOCK.
- err  output  1  one-cycle pulse on a mismatch in LOCK.
- restart  output  1  one-cycle pulse when 8 is seen in SYNC or LOCK.
- loop_done  output  1  one-cycle pulse when a correct 1 is received in LOCK.
- expect_q  output  4  next expected value; 0 while in HUNT.
- loop_cnt  output  CNT_W  loops completed; wraps modulo 2^CNT_W.
- err_cnt  output  CNT_W  mismatches counted; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HUNT.
  - locked=0, err=0, restart=0, loop_done=0, expect_q=0.
  - loop_cnt=0, err_cnt=0, internal match/miss counters=0.
- All outputs are registered. A sample accepted at edge N is reflected in the outputs after edge N.
- Successor function succ(v): succ(8)=7; succ(v)=v-1 for v in 2..7; succ(1)=7.
- Legal codes are 1..8. Codes 0 and 9..15 are illegal.
- Only cycles with cq_valid=1 are evaluated. With cq_valid=0, every register holds and every pulse output is 0.
- HUNT:
  - Legal v: go to SYNC, expect_q=succ(v), match=1.
  - Illegal v: stay in HUNT.
  - No err pulses and no err_cnt changes in HUNT.
- SYNC:
  - v==expect_q: match+1, expect_q=succ(v). If match+1 reaches LOCK_THRESH, go to LOCK, locked=1, miss=0.
  - v==8: restart pulse, expect_q=7, match=1, stay in SYNC.
  - Any other v: return to HUNT, expect_q=0, match=0. No err pulse.
- LOCK:
  - v==expect_q:
    - miss=0, expect_q=succ(v).
    - If v==1: loop_done pulse, loop_cnt+1 (wrapping).
  - v==8:
    - restart pulse, expect_q=7, miss=0, stay in LOCK.
    - Not an error; loop_cnt is unchanged.
  - Otherwise (mismatch, including illegal codes):
    - err pulse, err_cnt+1 (saturating), miss+1.
    - Flywheel: expect_q=succ(expect_q).
    - If miss+1 reaches LOSS_THRESH: go to HUNT, locked=0 on the same edge, expect_q=0, match=0.
- Lock timing: with LOCK_THRESH=3 and a clean stream, locked rises after the 3rd valid sample's edge.
- Pulse exclusivity: err, restart and loop_done are mutually exclusive in any cycle.
- Reset mid-operation: immediate return to reset values. Counters are cleared as well.
- Counter width rules: match and miss counters are sized to hold their threshold. Thresholds below 1 are not supported.

Test Plan:
- Reset release, then a clean stream 8,7,6,5,4,3,2,1,7 at cq_valid=1 every cycle:
  - restart pulse on the 8 sample's edge is suppressed (HUNT entry).
  - locked=1 after the 3rd sample.
  - loop_done pulses once on the 1.
  - loop_cnt=1, err_cnt=0.
- Locked stream 5,4,9,2,1:
  - err pulses on the 9.
  - err_cnt=1, locked stays 1 (flywheel expects 2).
  - loop_done fires on the 1.
- Locked stream 5,4,6,6:
  - err pulses twice, err_cnt=2.
  - locked=0 after the 2nd mismatch, state=HUNT, expect_q=0.
- Locked stream 3,8,7:
  - restart pulses on the 8.
  - err_cnt unchanged, expect_q=6 after the 7.
- Clean stream with cq_valid toggling 1,0,1,0:
  - Outputs update only on valid cycles.
  - Lock takes 3 valid samples (6 clocks).
- Force err_cnt to 255 via repeated lose/relock sequences, then 1 more mismatch:
  - err_cnt stays 255.
- Assert rst low mid-loop, asynchronously between edges:
  - All outputs go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fsm7_seq_checker_if.sv
// Sequence bus from the 7-state counter FSM plus the checker's status outputs.
// master drives cq_in/cq_valid and observes status; slave is the checker side.
interface fsm7_seq_checker_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       cq_in;
  logic             cq_valid;
  logic             locked;
  logic             err;
  logic             restart;
  logic             loop_done;
  logic [3:0]       expect_q;
  logic [CNT_W-1:0] loop_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output cq_in, cq_valid,
    input  locked, err, restart, loop_done, expect_q, loop_cnt, err_cnt
  );

  modport slave (
    input  cq_in, cq_valid,
    output locked, err, restart, loop_done, expect_q, loop_cnt, err_cnt
  );
endinterface

// File: rtl/fsm7_seq_checker.sv
// Locks onto the 8,7..1,7.. counter sequence, flags mismatches/restarts, counts loops and errors.
// Outputs are registered (one edge after the sample); no backpressure, cq_valid=0 simply freezes state.
module fsm7_seq_checker #(
  parameter int LOCK_THRESH = 3,
  parameter int LOSS_THRESH = 2,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              rst,
  fsm7_seq_checker_if.slave bus
);

  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         expect_r, expect_nxt;
  logic [MATCH_W-1:0] match_r, match_nxt;
  logic [MISS_W-1:0]  miss_r, miss_nxt;
  logic [CNT_W-1:0]   loop_cnt_r, loop_cnt_nxt;
  logic [CNT_W-1:0]   err_cnt_r, err_cnt_nxt;
  logic               err_r, err_nxt;
  logic               restart_r, restart_nxt;
  logic               loop_done_r, loop_done_nxt;
  logic               legal;

  function automatic logic [3:0] succ(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'd8, 4'd1:                          r = 4'd7;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:  r = v - 4'd1;
      default:                             r = 4'd0;
    endcase
    return r;
  endfunction

  assign legal = (bus.cq_in >= 4'd1) && (bus.cq_in <= 4'd8);

  always_comb begin
    state_nxt     = state;
    expect_nxt    = expect_r;
    match_nxt     = match_r;
    miss_nxt      = miss_r;
    loop_cnt_nxt  = loop_cnt_r;
    err_cnt_nxt   = err_cnt_r;
    err_nxt       = 1'b0;
    restart_nxt   = 1'b0;
    loop_done_nxt = 1'b0;

    if (bus.cq_valid) begin
      case (state)
        HUNT: begin
          if (legal) begin
            state_nxt  = SYNC;
            expect_nxt = succ(bus.cq_in);
            match_nxt  = MATCH_W'(1);
          end
        end

        SYNC: begin
          if (bus.cq_in == expect_r) begin
            match_nxt  = match_r + 1'b1;
            expect_nxt = succ(bus.cq_in);
            if (int'(match_r) + 1 >= LOCK_THRESH) begin
              state_nxt = LOCK;
              miss_nxt  = '0;
            end
          end else if (bus.cq_in == 4'd8) begin
            restart_nxt = 1'b1;
            expect_nxt  = 4'd7;
            match_nxt   = MATCH_W'(1);
          end else begin
            state_nxt  = HUNT;
            expect_nxt = 4'd0;
            match_nxt  = '0;
          end
        end

        LOCK: begin
          if (bus.cq_in == expect_r) begin
            miss_nxt   = '0;
            expect_nxt = succ(bus.cq_in);
            if (bus.cq_in == 4'd1) begin
              loop_done_nxt = 1'b1;
              loop_cnt_nxt  = loop_cnt_r + 1'b1;
            end
          end else if (bus.cq_in == 4'd8) begin
            restart_nxt = 1'b1;
            expect_nxt  = 4'd7;
            miss_nxt    = '0;
          end else begin
            err_nxt = 1'b1;
            if (err_cnt_r != '1) begin
              err_cnt_nxt = err_cnt_r + 1'b1;
            end
            // Flywheel: keep advancing the expectation so one glitch doesn't desync us.
            if (int'(miss_r) + 1 >= LOSS_THRESH) begin
              state_nxt  = HUNT;
              expect_nxt = 4'd0;
              match_nxt  = '0;
              miss_nxt   = '0;
            end else begin
              miss_nxt   = miss_r + 1'b1;
              expect_nxt = succ(expect_r);
            end
          end
        end

        default: begin
          state_nxt  = HUNT;
          expect_nxt = 4'd0;
          match_nxt  = '0;
          miss_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HUNT;
      expect_r    <= 4'd0;
      match_r     <= '0;
      miss_r      <= '0;
      loop_cnt_r  <= '0;
      err_cnt_r   <= '0;
      err_r       <= 1'b0;
      restart_r   <= 1'b0;
      loop_done_r <= 1'b0;
    end else begin
      state       <= state_nxt;
      expect_r    <= expect_nxt;
      match_r     <= match_nxt;
      miss_r      <= miss_nxt;
      loop_cnt_r  <= loop_cnt_nxt;
      err_cnt_r   <= err_cnt_nxt;
      err_r       <= err_nxt;
      restart_r   <= restart_nxt;
      loop_done_r <= loop_done_nxt;
    end
  end

  assign bus.locked    = (state == LOCK);
  assign bus.err       = err_r;
  assign bus.restart   = restart_r;
  assign bus.loop_done = loop_done_r;
  assign bus.expect_q  = expect_r;
  assign bus.loop_cnt  = loop_cnt_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_fsm7_seq_checker.sv
// Randomized and directed bench for fsm7_seq_checker against a behavioural sequence model.
module tb_fsm7_seq_checker;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  fsm7_seq_checker_if #(.CNT_W(CNT_W)) bus ();

  fsm7_seq_checker #(
    .LOCK_THRESH(3),
    .LOSS_THRESH(2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = searching, 1 = gathering matches, 2 = locked.
  int m_phase, m_exp, m_run, m_miss, m_loops, m_errs;
  bit m_err, m_restart, m_done;

  function automatic int nxt(input int v);
    return (v == 8 || v == 1) ? 7 : v - 1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_exp = 0; m_run = 0; m_miss = 0;
    m_loops = 0; m_errs = 0;
    m_err = 0; m_restart = 0; m_done = 0;
  endtask

  task automatic model_step(input int v, input bit valid);
    m_err = 0; m_restart = 0; m_done = 0;
    if (valid) begin
      if (m_phase == 0) begin
        if (v >= 1 && v <= 8) begin
          m_phase = 1; m_exp = nxt(v); m_run = 1;
        end
      end else if (m_phase == 1) begin
        if (v == m_exp) begin
          m_run = m_run + 1; m_exp = nxt(v);
          if (m_run >= 3) begin m_phase = 2; m_miss = 0; end
        end else if (v == 8) begin
          m_restart = 1; m_exp = 7; m_run = 1;
        end else begin
          m_phase = 0; m_exp = 0; m_run = 0;
        end
      end else begin
        if (v == m_exp) begin
          m_miss = 0; m_exp = nxt(v);
          if (v == 1) begin m_done = 1; m_loops = (m_loops + 1) % 256; end
        end else if (v == 8) begin
          m_restart = 1; m_exp = 7; m_miss = 0;
        end else begin
          m_err = 1;
          m_errs = (m_errs < 255) ? m_errs + 1 : 255;
          m_miss = m_miss + 1;
          if (m_miss >= 2) begin
            m_phase = 0; m_exp = 0; m_run = 0; m_miss = 0;
          end else begin
            m_exp = nxt(m_exp);
          end
        end
      end
    end
  endtask

  function automatic logic [23:0] exp_vec();
    return {(m_phase == 2), m_err, m_restart, m_done, 4'(m_exp), 8'(m_loops), 8'(m_errs)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {bus.locked, bus.err, bus.restart, bus.loop_done, bus.expect_q, bus.loop_cnt, bus.err_cnt};
  endfunction

  task automatic drive(input int v, input bit valid);
    bus.cq_in    = 4'(v);
    bus.cq_valid = valid;
    @(posedge clk);
    model_step(v, valid);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.cq_valid = 1'b0;
    bus.cq_in    = 4'd0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic lock_up();
    do_reset();
    drive(8, 1); drive(7, 1); drive(6, 1);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (dut_vec() !== 24'h0) begin
      n_fail++; $display("FAIL reset_state: got %h want 000000", dut_vec());
    end
    drive(0, 1);
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL hunt_illegal: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_clean_lock();
    int seq [9] = '{8, 7, 6, 5, 4, 3, 2, 1, 7};
    int dones = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(seq[i], 1);
      dones += int'(bus.loop_done);
      if (i == 0) begin
        n_tests++;
        if ({bus.restart, bus.locked, bus.expect_q} !== {1'b0, 1'b0, 4'd7}) begin
          n_fail++; $display("FAIL first_8: got r=%b l=%b e=%0d want r=0 l=0 e=7", bus.restart, bus.locked, bus.expect_q);
        end
      end else if (i == 1) begin
        n_tests++;
        if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL early_lock: got %b want 0", bus.locked); end
      end else if (i == 2) begin
        n_tests++;
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_after_3: got %b want 1", bus.locked); end
      end
    end
    n_tests++;
    if (dones != 1) begin n_fail++; $display("FAIL loop_done_count: got %0d want 1", dones); end
    n_tests++;
    if ({bus.loop_cnt, bus.err_cnt, bus.expect_q} !== {8'd1, 8'd0, 4'd6}) begin
      n_fail++; $display("FAIL clean_counts: got loop=%0d err=%0d e=%0d want 1 0 6", bus.loop_cnt, bus.err_cnt, bus.expect_q);
    end
  endtask

  task automatic test_flywheel();
    lock_up();
    drive(5, 1); drive(4, 1); drive(9, 1);
    n_tests++;
    if ({bus.err, bus.locked, bus.expect_q} !== {1'b1, 1'b1, 4'd2}) begin
      n_fail++; $display("FAIL flywheel_err: got err=%b l=%b e=%0d want 1 1 2", bus.err, bus.locked, bus.expect_q);
    end
    drive(2, 1); drive(1, 1);
    n_tests++;
    if ({bus.loop_done, bus.err_cnt, bus.loop_cnt, bus.locked} !== {1'b1, 8'd1, 8'd1, 1'b1}) begin
      n_fail++; $display("FAIL flywheel_recover: got ld=%b errc=%0d loops=%0d l=%b want 1 1 1 1", bus.loop_done, bus.err_cnt, bus.loop_cnt, bus.locked);
    end
  endtask

  task automatic test_loss();
    lock_up();
    drive(5, 1); drive(4, 1); drive(6, 1);
    n_tests++;
    if ({bus.err, bus.locked, bus.expect_q} !== {1'b1, 1'b1, 4'd2}) begin
      n_fail++; $display("FAIL loss_first: got err=%b l=%b e=%0d want 1 1 2", bus.err, bus.locked, bus.expect_q);
    end
    drive(6, 1);
    n_tests++;
    if ({bus.err, bus.locked, bus.expect_q, bus.err_cnt} !== {1'b1, 1'b0, 4'd0, 8'd2}) begin
      n_fail++; $display("FAIL loss_second: got err=%b l=%b e=%0d errc=%0d want 1 0 0 2", bus.err, bus.locked, bus.expect_q, bus.err_cnt);
    end
  endtask

  task automatic test_restart();
    lock_up();
    drive(5, 1); drive(4, 1); drive(3, 1); drive(8, 1);
    n_tests++;
    if ({bus.restart, bus.err, bus.locked, bus.expect_q} !== {1'b1, 1'b0, 1'b1, 4'd7}) begin
      n_fail++; $display("FAIL restart_pulse: got r=%b err=%b l=%b e=%0d want 1 0 1 7", bus.restart, bus.err, bus.locked, bus.expect_q);
    end
    drive(7, 1);
    n_tests++;
    if ({bus.restart, bus.expect_q, bus.err_cnt, bus.loop_cnt} !== {1'b0, 4'd6, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL restart_after: got r=%b e=%0d errc=%0d loops=%0d want 0 6 0 0", bus.restart, bus.expect_q, bus.err_cnt, bus.loop_cnt);
    end
  endtask

  task automatic test_valid_toggle();
    do_reset();
    drive(8, 1); drive(7, 0);
    n_tests++;
    if ({bus.locked, bus.expect_q} !== {1'b0, 4'd7}) begin
      n_fail++; $display("FAIL idle_hold1: got l=%b e=%0d want 0 7", bus.locked, bus.expect_q);
    end
    drive(7, 1); drive(5, 0);
    n_tests++;
    if ({bus.locked, bus.expect_q} !== {1'b0, 4'd6}) begin
      n_fail++; $display("FAIL idle_hold2: got l=%b e=%0d want 0 6", bus.locked, bus.expect_q);
    end
    drive(6, 1); drive(9, 0);
    n_tests++;
    if ({bus.locked, bus.err, bus.restart, bus.loop_done, bus.expect_q} !== {1'b1, 3'b000, 4'd5}) begin
      n_fail++; $display("FAIL idle_lock: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_err_sat();
    do_reset();
    repeat (127) begin
      drive(8, 1); drive(7, 1); drive(6, 1); drive(0, 1); drive(0, 1);
    end
    n_tests++;
    if (bus.err_cnt !== 8'd254) begin n_fail++; $display("FAIL err_cnt_254: got %0d want 254", bus.err_cnt); end
    drive(8, 1); drive(7, 1); drive(6, 1); drive(0, 1);
    n_tests++;
    if ({bus.err, bus.err_cnt} !== {1'b1, 8'd255}) begin
      n_fail++; $display("FAIL err_cnt_255: got err=%b cnt=%0d want 1 255", bus.err, bus.err_cnt);
    end
    drive(0, 1);
    n_tests++;
    if ({bus.err, bus.err_cnt, bus.locked} !== {1'b1, 8'd255, 1'b0}) begin
      n_fail++; $display("FAIL err_cnt_sat: got err=%b cnt=%0d l=%b want 1 255 0", bus.err, bus.err_cnt, bus.locked);
    end
  endtask

  task automatic test_async_reset();
    lock_up();
    drive(5, 1); drive(4, 1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec() !== 24'h0) begin n_fail++; $display("FAIL async_reset: got %h want 000000", dut_vec()); end
    @(posedge clk); #3;
    n_tests++;
    if (dut_vec() !== 24'h0) begin n_fail++; $display("FAIL reset_hold: got %h want 000000", dut_vec()); end
    rst = 1'b1;
    drive(8, 1); drive(7, 1); drive(6, 1);
    n_tests++;
    if (dut_vec() !== exp_vec() || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL relock_after_reset: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int src, v, r;
    bit valid;
    do_reset();
    src = 8;
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 99);
      if (r < 85)      v = src;
      else if (r < 90) v = 8;
      else             v = $urandom_range(0, 15);
      if (valid) src = (v == 8) ? 7 : nxt(src);
      drive(v, valid);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_step %0d v=%0d vld=%b: got %h want %h", i, v, valid, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.cq_in = 4'd0;
    bus.cq_valid = 1'b0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_flywheel();
    test_loss();
    test_restart();
    test_valid_toggle();
    test_err_sat();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
